mp_add_seq: RTL and testbench

Digit-serial multi-precision add/subtract sequencer for the Barrett modular multiplication datapath. It accepts two W-bit operands and computes A+B or A−B through one DW-bit ripple-carry adder, one digit per cycle, LSB digit first. Carry/borrow is held in a register between digits. It serves the wide additions and the final conditional-subtract compare (A ≥ B) of the Barrett reduction, so a full-width adder is not needed.

---
 rtl/barrett_pkg.sv | 13 +
 rtl/RCA.sv | 23 ++
 rtl/mp_add_seq.sv | 129 ++++++++++++
 tb/tb_mp_add_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// rtl/barrett_pkg.sv - shared types and default widths for the Barrett datapath
package barrett_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF  = 64;
  localparam int DW_DEF = 8;

endpackage

// File: rtl/RCA.sv
// rtl/RCA.sv - n-bit ripple-carry adder built from a chain of full adders
module RCA #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         C_in,
  output logic [n-1:0] s,
  output logic         C_out
);

  logic [n:0] c;

  assign c[0] = C_in;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign C_out = c[n];

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - digit-serial W-bit add/subtract through one DW-bit ripple adder
module mp_add_seq
  import barrett_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int NDIG = W / DW;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (W % DW != 0) begin : g_bad_width
    $error("mp_add_seq: W must be a multiple of DW");
  end

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           sub_reg;
  logic           c_out_reg;
  logic [W-1:0]   a_reg, b_reg, sum_reg, sum_shift;
  logic [DW-1:0]  dig_x, dig_y, dig_s;
  logic           dig_c;
  logic           accept;
  logic           last;

  // Subtraction feeds ~B into the adder; the +1 comes from carry preloaded with op_sub.
  assign dig_x = a_reg[DW-1:0];
  assign dig_y = b_reg[DW-1:0] ^ {DW{sub_reg}};
  assign last  = (cnt == LAST);

  RCA #(.n(DW)) u_rca (
    .a     (dig_x),
    .b     (dig_y),
    .C_in  (carry),
    .s     (dig_s),
    .C_out (dig_c)
  );

  if (NDIG == 1) begin : g_one_digit
    assign sum_shift = dig_s;
  end else begin : g_multi_digit
    assign sum_shift = {dig_s, sum_reg[W-1:DW]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      sub_reg   <= 1'b0;
      carry     <= 1'b0;
      c_out_reg <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      sub_reg <= op_sub;
      carry   <= op_sub;
      cnt     <= '0;
    end else if (state == RUN) begin
      // Result digits enter at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
      sum_reg <= sum_shift;
      a_reg   <= a_reg >> DW;
      b_reg   <= b_reg >> DW;
      carry   <= dig_c;
      cnt     <= cnt + CW'(1);
      if (last) begin
        c_out_reg <= dig_c;
      end
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - self-checking bench for mp_add_seq (W=64/DW=8 and W=DW=8)
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op_sub;
  logic [63:0] a, b;
  logic        ready, done;
  logic [63:0] sum;
  logic        c_out;

  logic        start8, op8;
  logic [7:0]  a8, b8;
  logic        ready8, done8;
  logic [7:0]  sum8;
  logic        c8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.W(64), .DW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .c_out(c_out)
  );

  mp_add_seq #(.W(8), .DW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_sub(op8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .sum(sum8), .c_out(c8)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] s;
    logic        c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, {c_out, sum}
  function automatic logic [64:0] model(input logic op, input logic [63:0] x, input logic [63:0] y);
    if (op) return {(x >= y), x - y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic run_op(input logic op, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] s, output logic c, output int lat, output int rlow);
    @(negedge clk);
    start = 1'b1; op_sub = op; a = x; b = y;
    lat = -1; rlow = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!ready) rlow++;
    end
    s = sum; c = c_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [63:0] s, s1, s2;
    logic        c, c1, c2;
    logic [64:0] m;
    int          lat, rlow, ndone, d1, d2;
    logic        op;
    logic [63:0] x, y;

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", sum, 64'd0);
    chk("reset_c_out", 64'(c_out), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"carry_ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1});
    vecs.push_back('{"borrow", 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"sub_equal", 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1});
    vecs.push_back('{"add_zero", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{"sub_zero_one", 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"add_msb_ovf", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1});
    vecs.push_back('{"sub_max_zero", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"add_digits", 1'b0, 64'h0102_0304_0506_0708, 64'h10F0_20E0_30D0_40C0, 64'h11F2_23E4_35D6_47C8, 1'b0});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, s, c, lat, rlow);
      chk({vecs[i].name, "_sum"}, s, vecs[i].s);
      chk({vecs[i].name, "_c_out"}, 64'(c), 64'(vecs[i].c));
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'd9);
      chk({vecs[i].name, "_ready_low"}, 64'(rlow), 64'd8);
    end

    // Busy protection: second start mid-run must be dropped
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 64'd100; b = 64'd200;
    ndone = 0; d1 = -1; s1 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; a = 64'd1; b = 64'd1; end
      if (k == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (d1 < 0) begin d1 = k; s1 = sum; end
      end
    end
    chk("busy_done_count", 64'(ndone), 64'd1);
    chk("busy_latency", 64'(d1), 64'd9);
    chk("busy_sum", s1, 64'd300);
    chk("busy_sum_hold", sum, 64'd300);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    start = 1'b1; op_sub = 1'b1; a = 64'd1000; b = 64'd1;
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (d1 >= 0 && k == d1 + 1) start = 1'b0;
      if (done) begin
        if (d1 < 0) begin
          d1 = k; s1 = sum; c1 = c_out;
          op_sub = 1'b0; a = 64'd5; b = 64'd6;
        end else begin
          d2 = k; s2 = sum; c2 = c_out;
          break;
        end
      end
    end
    chk("b2b_first_latency", 64'(d1), 64'd9);
    chk("b2b_first_sum", s1, 64'd999);
    chk("b2b_first_c_out", 64'(c1), 64'd1);
    chk("b2b_spacing", 64'(d2 - d1), 64'd9);
    chk("b2b_second_sum", s2, 64'd11);
    chk("b2b_second_c_out", 64'(c2), 64'd0);

    // Reset mid-run
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready), 64'd1);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_sum", sum, 64'd0);
    chk("rst_mid_c_out", 64'(c_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    run_op(1'b1, 64'd50, 64'd20, s, c, lat, rlow);
    chk("rst_after_sum", s, 64'd30);
    chk("rst_after_c_out", 64'(c), 64'd1);
    chk("rst_after_latency", 64'(lat), 64'd9);

    // Degenerate W == DW
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start8 = 1'b1;
      op8 = (t == 1);
      a8 = (t == 0) ? 8'hFF : 8'h03;
      b8 = (t == 0) ? 8'h01 : 8'h05;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k == 1) start8 = 1'b0;
        if (done8) begin lat = k; break; end
      end
      chk("w8_latency", 64'(lat), 64'd2);
      chk("w8_sum", 64'(sum8), (t == 0) ? 64'h00 : 64'hFE);
      chk("w8_c_out", 64'(c8), (t == 0) ? 64'd1 : 64'd0);
    end

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      y = (i % 8 == 7) ? x : {$urandom, $urandom};
      if (i % 5 == 4) y = y >> $urandom_range(1, 63);
      m = model(op, x, y);
      run_op(op, x, y, s, c, lat, rlow);
      chk("rand_sum", s, m[63:0]);
      chk("rand_c_out", 64'(c), 64'(m[64]));
      chk("rand_latency", 64'(lat), 64'd9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
